// File: rtl/imem_pkg.sv
// imem_pkg: shared state encodings and default widths for the synchronous instruction memory.
package imem_pkg;
   typedef enum logic [1:0] {EMPTY = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 8;
   localparam logic [31:0] DEF_NOP_WORD = 32'h0000_0000;
endpackage

// File: rtl/imem_array.sv
// imem_array: DEPTH x DATA_WIDTH RAM, one write port, one synchronous read port, no reset.
module imem_array #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH = 256,
   parameter int IW = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [IW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [IW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/imem_sync.sv
// imem_sync: word-serial loaded instruction memory with a registered, bounds-checked fetch port.
module imem_sync
   import imem_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DEPTH = 256,
   parameter logic [DATA_WIDTH-1:0] NOP_WORD = DATA_WIDTH'(DEF_NOP_WORD)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_start,
   input  logic                  load_valid,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  load_done,
   output logic                  load_ready,
   output logic                  load_ovf,
   output logic                  loaded,
   output logic [ADDR_WIDTH:0]   word_count,
   input  logic                  fetch_req,
   input  logic [ADDR_WIDTH-1:0] fetch_addr,
   output logic                  fetch_valid,
   output logic [DATA_WIDTH-1:0] fetch_data,
   output logic                  fetch_err
);
   localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(DEPTH);
   state_t state, nxt;
   logic we, good, ok_q;
   logic [DATA_WIDTH-1:0] rdata;
   assign nxt = load_start ? LOAD : (state == LOAD && load_done) ? RUN : state;
   assign we = state == LOAD && load_valid && !load_start && word_count != FULL;
   assign good = state == RUN && {1'b0, fetch_addr} < word_count;
   // ok_q selects the array output only for a good fetch, so reset and errors show NOP_WORD
   assign fetch_data = ok_q ? rdata : NOP_WORD;
   imem_array #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .IW(IW)) u_array (
      .clk(clk),
      .we(we),
      .waddr(word_count[IW-1:0]),
      .wdata(load_data),
      .re(fetch_req && good),
      .raddr(fetch_addr[IW-1:0]),
      .rdata(rdata)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= EMPTY;
         load_ready <= 1'b0;
         loaded <= 1'b0;
         word_count <= '0;
         load_ovf <= 1'b0;
         fetch_valid <= 1'b0;
         fetch_err <= 1'b0;
         ok_q <= 1'b0;
      end else begin
         state <= nxt;
         load_ready <= nxt == LOAD;
         loaded <= nxt == RUN;
         if (load_start) begin
            word_count <= '0;
            load_ovf <= 1'b0;
         end else if (state == LOAD && load_valid) begin
            if (word_count == FULL) load_ovf <= 1'b1;
            else word_count <= word_count + (ADDR_WIDTH+1)'(1);
         end
         fetch_valid <= fetch_req;
         if (fetch_req) begin
            ok_q <= good;
            fetch_err <= !good;
         end
      end
   end
endmodule
